// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_RD : default configuration
//   ZERO_REG                             : hard-wired zero register address
//   wport_t                              : write-port bundle (we, addr, data)
//                                          at the default widths
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_NUM_RD = 2;
    localparam int unsigned ZERO_REG   = 0;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wport_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus between the issue/write-back stages and regfile_mp.
//   raddr    : NUM_RD packed read addresses (port k at [k*ADDR_W +: ADDR_W])
//   rdata    : NUM_RD packed read data      (port k at [k*DATA_W +: DATA_W])
//   rbusy    : scoreboard busy flag per read port
//   we0/waddr0/wdata0 : write-back port 0
//   we1/waddr1/wdata1 : write-back port 1 (wins on same-address conflict)
//   iss_v/iss_addr    : issue of an instruction writing iss_addr
// master: pipeline side, slave: register file side.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD
);

    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic                     iss_v;
    logic [ADDR_W-1:0]        iss_addr;

    modport master (
        output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, iss_v, iss_addr,
        input  rdata, rbusy
    );

    modport slave (
        input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, iss_v, iss_addr,
        output rdata, rbusy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per register for RAW hazard detection.
//   clk, rst     : clock, synchronous active-low reset
//   i_set_v      : issue to a nonzero destination (sets busy)
//   i_set_addr   : issued destination
//   i_clr_v      : per write port, a committing write (clears busy)
//   i_clr_addr   : per write port, packed write addresses
//   i_raddr      : packed read addresses
//   o_busy       : busy flag per read port
// Optional: REGFILE_BYPASS_EN forwards same-cycle clears to o_busy unless
// the same register is being re-issued in that cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_set_v,
    input  logic [ADDR_W-1:0]        i_set_addr,
    input  logic [1:0]               i_clr_v,
    input  logic [2*ADDR_W-1:0]      i_clr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD-1:0]        o_busy
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W-1:0] w_ra [NUM_RD];

    // Clears first, then set: a new producer issued in the same cycle as the
    // old one's write-back keeps the register busy.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned p = 0; p < 2; p++) begin
            if (i_clr_v[p]) begin
                w_busy_nxt[i_clr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (i_set_v) begin
            w_busy_nxt[i_set_addr] = 1'b1;
        end
        w_busy_nxt[ADDR_W'(ZERO_REG)] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        o_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            w_ra[k]   = i_raddr[k*ADDR_W +: ADDR_W];
            o_busy[k] = r_busy[w_ra[k]];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned p = 0; p < 2; p++) begin
                if (i_clr_v[p] && (i_clr_addr[p*ADDR_W +: ADDR_W] == w_ra[k]) &&
                    !(i_set_v && (i_set_addr == w_ra[k]))) begin
                    o_busy[k] = 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read, dual-write register file with an
// integrated busy-bit scoreboard. Entry 0 reads as zero and is never busy.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-low reset (clears data and busy bits)
//   bus  : regfile_mp_if slave (read ports, two write ports, issue port)
// Optional: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding of
// data and busy clears (write port 1 takes precedence over port 0).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    // Same layout as wport_t, sized to this instance.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wport_p_t;

    wport_p_t          w_wp [2];
    logic [1:0]        w_wr;
    logic              w_set;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] w_raddr [NUM_RD];
    logic [DATA_W-1:0] w_rdata [NUM_RD];

    always_comb begin
        w_wp[0] = '{we: bus.we0, addr: bus.waddr0, data: bus.wdata0};
        w_wp[1] = '{we: bus.we1, addr: bus.waddr1, data: bus.wdata1};
        for (int unsigned p = 0; p < 2; p++) begin
            w_wr[p] = w_wp[p].we && (w_wp[p].addr != ADDR_W'(ZERO_REG));
        end
        w_set = bus.iss_v && (bus.iss_addr != ADDR_W'(ZERO_REG));
    end

    // Port 1 is applied last so it wins a same-address conflict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                if (w_wr[p]) begin
                    r_mem[w_wp[p].addr] <= w_wp[p].data;
                end
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            w_raddr[k] = bus.raddr[k*ADDR_W +: ADDR_W];
            w_rdata[k] = r_mem[w_raddr[k]];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned p = 0; p < 2; p++) begin
                if (w_wr[p] && (w_wp[p].addr == w_raddr[k])) begin
                    w_rdata[k] = w_wp[p].data;
                end
            end
`endif
            if (w_raddr[k] == ADDR_W'(ZERO_REG)) begin
                w_rdata[k] = '0;
            end
            bus.rdata[k*DATA_W +: DATA_W] = w_rdata[k];
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set_v    (w_set),
        .i_set_addr (bus.iss_addr),
        .i_clr_v    (w_wr),
        .i_clr_addr ({bus.waddr1, bus.waddr0}),
        .i_raddr    (bus.raddr),
        .o_busy     (bus.rbusy)
    );

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the two-read/one-write CPU register file.
- Configurable data width, depth and read-port count; two write-back ports with fixed priority.
- Integrated busy-bit scoreboard for RAW hazard detection by the issue stage.
- Sits between decode/issue (reads, scoreboard set) and write-back (writes, scoreboard clear) of the multi-issue datapath.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W, entry 0 hard-wired zero.
- NUM_RD, 2, number of independent read ports (1..4).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- raddr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W].
- rbusy  out  NUM_RD  scoreboard busy flag for each read address.
- we0  in  1  write enable, write port 0.
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, write port 1 (higher priority).
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- iss_v  in  1  issue valid; marks destination busy.
- iss_addr  in  ADDR_W  destination register of the issued instruction.

Behaviour:
- Reset (rst==0 at posedge clk):
  - All entries cleared to 0 and all busy bits cleared.
  - Reset overrides any same-cycle write or issue.
  - After reset, every rdata reads 0 and every rbusy reads 0.
- Reads:
  - Combinational, zero latency.
  - Address 0 always returns 0 and rbusy=0.
- Writes:
  - Take effect at posedge when weN=1 and waddrN!=0.
  - Writes to address 0 are discarded.
  - If both ports target the same nonzero address in one cycle, port 1's data is stored and port 0's is dropped.
- Scoreboard:
  - One busy bit per entry (entry 0 constant 0).
  - Set: iss_v=1 and iss_addr!=0 sets busy[iss_addr] at posedge.
  - Clear: a write from either port clears busy[waddrN] at posedge.
  - Same-cycle set and clear on the same address: set wins, because the newer producer is outstanding.
  - Clears on different addresses from both ports are independent.
  - rbusy[k] = busy[raddr k] as registered state (no combinational clear-forwarding; see optional feature).
- Simultaneous read and write to the same address: without bypass, rdata shows the pre-write value until the next cycle.
- No overflow or wrap conditions: fixed-size storage, and the scoreboard is saturating (setting an already-busy bit leaves it busy).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If weN=1, waddrN!=0 and waddrN==raddr k, rdata k returns wdataN in the same cycle; port 1 takes precedence over port 0.
  - rbusy k is forced to 0 in the same case, unless iss_v=1 with iss_addr equal to that address.
- Undefined: reads and rbusy reflect registered state only. The issue stage must stall one extra cycle after write-back.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W/NUM_RD constants;
  - the ZERO_REG address constant;
  - the typedef for the write-port bundle (we, addr, data).
- One natural sub-module, regfile_scoreboard, implements the busy-bit vector with set/clear priority and per-read-port lookup. It takes the same clk/rst.
- Storage array and read muxes stay in the top module.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert rst=0 for one cycle → rdata(r5)=0, rbusy=0 on all ports.
- Register 0:
  - we0=1, waddr0=0, wdata0=0x12345678 → raddr=0 reads 0.
  - iss_v=1, iss_addr=0 → rbusy=0.
- Dual-write conflict: we0/we1 both to r7 with 0x11111111 / 0x22222222 → next cycle r7=0x22222222.
  - Separate addresses r3/r4 → both stored.
- Scoreboard:
  - iss r9 → rbusy=1 next cycle.
  - Write r9 via port 0 → rbusy=0 next cycle.
  - Same-cycle issue r9 and write r9 → r9 updated and rbusy stays 1.
- Bypass: with r10=0xAAAA0000, write 0x0000BBBB to r10 while reading r10.
  - REGFILE_BYPASS_EN defined → same-cycle rdata=0x0000BBBB.
  - Undefined → same cycle 0xAAAA0000, next cycle 0x0000BBBB.
- NUM_RD=4, DATA_W=64: fill r1..r31 with index*0x0101010101010101, read four distinct addresses per cycle → all ports correct simultaneously.
